// File: rtl/uart_pkg.sv
// Shared UART transmitter definitions: FSM state encoding and line levels.
// Defining UART_TX_PARITY_EN adds the PARITY state to the frame.
package uart_pkg;

    localparam int   CLKS_PER_BIT_DEFAULT = 7292;
    localparam logic IDLE_LEVEL           = 1'b1;
    localparam logic START_LEVEL          = 1'b0;
    localparam logic STOP_LEVEL           = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO feeding the UART shifter. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; storage itself is never reset.
module uart_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [7:0]               i_data,
    input  logic                     i_pop,
    output logic                     o_accept,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [7:0]               o_data
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_pop;
    logic          w_do_push;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_accept  = w_do_push;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a byte FIFO, with a sticky overflow flag.
// Defining UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          clr_ovf,
    output logic                          tx_serial,
    output logic                          tx_active,
    output logic                          tx_done,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t     r_state;
    tx_state_t     w_state_nxt;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_overflow;
    logic          w_bit_end;
    logic          w_pop;
    logic          w_accept;
    logic [7:0]    w_head;
`ifdef UART_TX_PARITY_EN
    logic          r_parity;
`endif

    uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_push   (wr_en),
        .i_data   (wr_data),
        .i_pop    (w_pop),
        .o_accept (w_accept),
        .o_full   (fifo_full),
        .o_empty  (fifo_empty),
        .o_count  (fifo_count),
        .o_data   (w_head)
    );

    assign w_bit_end = (r_baud == BAUD_LAST);
    assign tx_done   = (r_state == ST_STOP) && w_bit_end;
    assign tx_active = (r_state != ST_IDLE);
    // The head is taken from idle, or at the last stop cycle so frames abut.
    assign w_pop     = !fifo_empty && ((r_state == ST_IDLE) || tx_done);
    assign overflow  = r_overflow;

    always_comb begin
        w_state_nxt = r_state;
        tx_serial   = IDLE_LEVEL;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) w_state_nxt = ST_START;
            end
            ST_START: begin
                tx_serial = START_LEVEL;
                if (w_bit_end) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                tx_serial = r_shift[0];
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = ST_PARITY;
`else
                    w_state_nxt = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_serial = r_parity;
                if (w_bit_end) w_state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                tx_serial = STOP_LEVEL;
                if (w_bit_end) w_state_nxt = w_pop ? ST_START : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) || w_bit_end) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + CW'(1);
            end
            if (w_pop) begin
                r_shift   <= w_head;
                r_bit_idx <= '0;
            end else if ((r_state == ST_DATA) && w_bit_end) begin
                r_shift   <= {1'b0, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^w_head;
        end
    end
`endif

    // A dropped push outranks a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (wr_en && !w_accept) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo (CLKS_PER_BIT=4, FIFO_DEPTH=4) against a frame-level
// reference model; honours UART_TX_PARITY_EN for the frame length and parity bit.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * CPB;
`else
    localparam int FRAME = 10 * CPB;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovf;
    logic       tx_serial;
    logic       tx_active;
    logic       tx_done;
    logic       fifo_full;
    logic       fifo_empty;
    logic [2:0] fifo_count;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    // Reference model: queued bytes, byte on the line, position in its frame.
    logic [7:0] exp_q[$];
    logic [7:0] m_byte;
    int         m_pos;
    logic       m_ovf;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .clr_ovf    (clr_ovf),
        .tx_serial  (tx_serial),
        .tx_active  (tx_active),
        .tx_done    (tx_done),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic exp_line();
        int b;
        if (m_pos < 0) return 1'b1;
        b = m_pos / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^m_byte;
`endif
        return 1'b1;
    endfunction

    function automatic logic exp_active();
        return m_pos >= 0;
    endfunction

    function automatic logic exp_done();
        return m_pos == FRAME - 1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_pos  = -1;
        m_byte = 8'h00;
        m_ovf  = 1'b0;
    endtask

    task automatic model_edge(input logic w, input logic [7:0] d, input logic c);
        logic pop;
        logic was_full;
        pop      = ((m_pos < 0) || (m_pos == FRAME - 1)) && (exp_q.size() > 0);
        was_full = (exp_q.size() == DEPTH);
        if (pop) m_byte = exp_q.pop_front();
        if (w && (!was_full || pop)) exp_q.push_back(d);
        if (w && was_full && !pop) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        if (pop) m_pos = 0;
        else if (m_pos >= 0) m_pos = (m_pos == FRAME - 1) ? -1 : m_pos + 1;
    endtask

    task automatic tick(input logic w, input logic [7:0] d, input logic c);
        wr_en   = w;
        wr_data = d;
        clr_ovf = c;
        @(posedge clk);
        model_edge(w, d, c);
        @(negedge clk);
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #2;
        checks++; if (tx_serial !== 1'b1) begin errors++; $display("FAIL rst_line: got %b expected 1", tx_serial); end
        checks++; if (tx_active !== 1'b0) begin errors++; $display("FAIL rst_active: got %b expected 0", tx_active); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", tx_done); end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", fifo_empty); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", fifo_full); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", overflow); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single_frame();
        int first_low = -1;
        int done_tick = -1;
        int done_cnt  = 0;
        do_reset();
        for (int t = 1; t <= FRAME + 10; t++) begin
            tick(t == 1, 8'hA5, 1'b0);
            if (tx_serial === 1'b0 && first_low < 0) first_low = t;
            if (tx_done === 1'b1) begin done_cnt++; done_tick = t; end
            checks++; if (tx_serial !== exp_line()) begin errors++; $display("FAIL a5_line t=%0d: got %b expected %b", t, tx_serial, exp_line()); end
            checks++; if (tx_active !== exp_active()) begin errors++; $display("FAIL a5_active t=%0d: got %b expected %b", t, tx_active, exp_active()); end
            checks++; if (tx_done !== exp_done()) begin errors++; $display("FAIL a5_done t=%0d: got %b expected %b", t, tx_done, exp_done()); end
        end
        checks++; if (first_low !== 2) begin errors++; $display("FAIL a5_latency: got %0d expected 2", first_low); end
        checks++; if (done_tick !== FRAME + 1) begin errors++; $display("FAIL a5_done_tick: got %0d expected %0d", done_tick, FRAME + 1); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL a5_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int done_ticks[$];
        int gaps = 0;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
        do_reset();
        for (int t = 1; t <= 3 * FRAME + 10; t++) begin
            tick(t <= 3, (t <= 3) ? bytes[t-1] : 8'h00, 1'b0);
            if (tx_done === 1'b1) done_ticks.push_back(t);
            if (t >= 2 && t <= 3 * FRAME + 1 && tx_active !== 1'b1) gaps++;
            checks++; if (tx_serial !== exp_line()) begin errors++; $display("FAIL b2b_line t=%0d: got %b expected %b", t, tx_serial, exp_line()); end
            checks++; if (tx_done !== exp_done()) begin errors++; $display("FAIL b2b_done t=%0d: got %b expected %b", t, tx_done, exp_done()); end
            checks++; if (fifo_count !== 3'(exp_q.size())) begin errors++; $display("FAIL b2b_count t=%0d: got %0d expected %0d", t, fifo_count, exp_q.size()); end
        end
        checks++; if (gaps !== 0) begin errors++; $display("FAIL b2b_gap: got %0d idle cycles expected 0", gaps); end
        checks++; if (done_ticks.size() !== 3) begin errors++; $display("FAIL b2b_done_cnt: got %0d expected 3", done_ticks.size()); end
        for (int i = 0; i < done_ticks.size() && i < 3; i++) begin
            checks++;
            if (done_ticks[i] !== FRAME * (i + 1) + 1) begin
                errors++; $display("FAIL b2b_done_tick%0d: got %0d expected %0d", i, done_ticks[i], FRAME * (i + 1) + 1);
            end
        end
    endtask

    task automatic test_overflow();
        int guard = 0;
        do_reset();
        for (int t = 1; t <= 6; t++) begin
            tick(1'b1, 8'(8'h10 + t), 1'b0);
            checks++; if (fifo_count !== 3'(exp_q.size())) begin errors++; $display("FAIL ovf_count t=%0d: got %0d expected %0d", t, fifo_count, exp_q.size()); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_flag t=%0d: got %b expected %b", t, overflow, m_ovf); end
        end
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", fifo_full); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        tick(1'b0, 8'h00, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
        tick(1'b1, 8'hEE, 1'b1);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_drop_wins: got %b expected 1", overflow); end
        tick(1'b0, 8'h00, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr2: got %b expected 0", overflow); end
        while (m_pos != FRAME - 1 && guard < 2 * FRAME) begin
            tick(1'b0, 8'h00, 1'b0);
            guard++;
        end
        checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL fullpop_done: got %b expected 1", tx_done); end
        tick(1'b1, 8'h3C, 1'b0);
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fullpop_count: got %0d expected 4", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %b expected 0", overflow); end
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fullpop_full: got %b expected 1", fifo_full); end
        for (int t = 0; t < 5 * FRAME + 5; t++) begin
            tick(1'b0, 8'h00, 1'b0);
            checks++; if (tx_serial !== exp_line()) begin errors++; $display("FAIL drain_line t=%0d: got %b expected %b", t, tx_serial, exp_line()); end
        end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", fifo_empty); end
    endtask

    task automatic test_mid_frame_reset();
        int guard = 0;
        do_reset();
        for (int t = 1; t <= 3; t++) tick(1'b1, 8'(8'hC0 + t), 1'b0);
        while (m_pos != 14 && guard < FRAME) begin
            tick(1'b0, 8'h00, 1'b0);
            guard++;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (tx_serial !== 1'b1) begin errors++; $display("FAIL mrst_line: got %b expected 1", tx_serial); end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL mrst_empty: got %b expected 1", fifo_empty); end
        checks++; if (tx_active !== 1'b0) begin errors++; $display("FAIL mrst_active: got %b expected 0", tx_active); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL mrst_done: got %b expected 0", tx_done); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int t = 0; t < 2 * FRAME; t++) begin
            tick(1'b0, 8'h00, 1'b0);
            checks++; if (tx_done !== exp_done()) begin errors++; $display("FAIL mrst_no_done t=%0d: got %b expected %b", t, tx_done, exp_done()); end
            checks++; if (tx_serial !== exp_line()) begin errors++; $display("FAIL mrst_idle t=%0d: got %b expected %b", t, tx_serial, exp_line()); end
        end
    endtask

    task automatic test_random();
        int rate;
        do_reset();
        for (int t = 0; t < 1600; t++) begin
            if (t % 200 == 0) rate = $urandom_range(2, 60);
            tick($urandom_range(0, 99) < rate, 8'($urandom_range(0, 255)), $urandom_range(0, 15) == 0);
            checks++; if (tx_serial !== exp_line()) begin errors++; $display("FAIL rnd_line t=%0d: got %b expected %b", t, tx_serial, exp_line()); end
            checks++; if (tx_active !== exp_active()) begin errors++; $display("FAIL rnd_active t=%0d: got %b expected %b", t, tx_active, exp_active()); end
            checks++; if (tx_done !== exp_done()) begin errors++; $display("FAIL rnd_done t=%0d: got %b expected %b", t, tx_done, exp_done()); end
            checks++; if (fifo_count !== 3'(exp_q.size())) begin errors++; $display("FAIL rnd_count t=%0d: got %0d expected %0d", t, fifo_count, exp_q.size()); end
            checks++; if (fifo_full !== (exp_q.size() == DEPTH)) begin errors++; $display("FAIL rnd_full t=%0d: got %b", t, fifo_full); end
            checks++; if (fifo_empty !== (exp_q.size() == 0)) begin errors++; $display("FAIL rnd_empty t=%0d: got %b", t, fifo_empty); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf t=%0d: got %b expected %b", t, overflow, m_ovf); end
        end
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        clr_ovf = 1'b0;
        model_reset();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_mid_frame_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 7292, clk cycles per serial bit (70 MHz / 9600 bps); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, byte entries; power of two, 2..64.
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  push strobe, one byte per asserted cycle (driven from the MMIO write to 0x40000018).
REQ-006 SHALL have port wr_data  input  8  byte to push.
REQ-007 SHALL have port clr_ovf  input  1  clears the overflow flag.
REQ-008 SHALL have port tx_serial  output  1  serial line, idle high.
REQ-009 SHALL have port tx_active  output  1  high while a frame is on the line.
REQ-010 SHALL have port tx_done  output  1  one-cycle pulse at end of each frame.
REQ-011 SHALL have port fifo_full  output  1  count == FIFO_DEPTH.
REQ-012 SHALL have port fifo_empty  output  1  count == 0.
REQ-013 SHALL have port fifo_count  output  log2(FIFO_DEPTH)+1  bytes queued, excluding the byte in the shifter.
REQ-014 SHALL have port overflow  output  1  sticky; set by a dropped push.

Function
REQ-015 SHALL use frame format 8N1: start bit 0, data LSB first, stop bit 1; every bit held exactly CLKS_PER_BIT cycles.
REQ-016 SHALL implement FSM IDLE -> START -> DATA(8 bits) -> [PARITY] -> STOP, with bit index 0..7 in DATA.
REQ-017 In IDLE with fifo_empty=0, the edge SHALL pop the head into the shifter, enter START and drive tx_serial=0; push-to-start-bit latency is 2 edges from an empty FIFO.
REQ-018 On the last STOP cycle, tx_done SHALL pulse for one cycle; if the FIFO is non-empty, the next frame's START SHALL begin on the following cycle with no idle gap, otherwise the FSM returns to IDLE.
REQ-019 tx_active SHALL be 1 in START/DATA/PARITY/STOP and 0 in IDLE.
REQ-020 A push while full without a same-cycle pop SHALL be dropped, set overflow, and leave contents unchanged.
REQ-021 A push and pop in the same cycle while full SHALL accept the push, with count unchanged.
REQ-022 Push and pop in the same cycle otherwise SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-023 clr_ovf SHALL clear overflow; a simultaneous dropped push SHALL win, leaving overflow=1.
REQ-024 The bit counter SHALL count 0..CLKS_PER_BIT-1 and reload on each bit boundary; there is no drift across back-to-back frames.

Reset
REQ-025 rst SHALL force FSM=IDLE, tx_serial=1, tx_active=0, tx_done=0, count=0, pointers=0, overflow=0, fifo_empty=1, fifo_full=0.
REQ-026 rst mid-frame SHALL abort the frame immediately, discard queued bytes, and never emit tx_done for the aborted frame.
REQ-027 FIFO storage contents SHALL NOT be reset.

Configuration
REQ-028 With UART_TX_PARITY_EN defined, a PARITY state SHALL insert an even-parity bit (XOR of the 8 data bits) between DATA and STOP, giving a frame of 11*CLKS_PER_BIT cycles.
REQ-029 Without UART_TX_PARITY_EN, the PARITY state SHALL be absent and the frame SHALL be 10*CLKS_PER_BIT cycles.

Structure
REQ-030 The shared package uart_pkg SHALL hold the FSM state typedef, the default CLKS_PER_BIT constant and the stop-bit/idle level constants.
REQ-031 The FIFO SHALL be the sub-module uart_byte_fifo (push, pop, full, empty, count, data out); uart_tx_fifo SHALL own the FSM, baud counter, shifter and overflow flag.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-032 Push 0xA5 once -> start bit begins 2 edges later; line reads 0,1,0,1,0,0,1,0,1,1, each for 4 cycles; tx_done pulses once at cycle 40.
REQ-033 Push 0x00,0xFF,0x55 back-to-back -> 3 contiguous frames (120 cycles) with no idle cycle between them; tx_done pulses 3 times, 40 cycles apart.
REQ-034 Push 6 bytes in consecutive cycles while idle -> first 5 are accepted (1 to shifter + 4 queued), the 6th is dropped, overflow=1 and fifo_full=1; clr_ovf -> overflow=0.
REQ-035 Full FIFO with push coinciding with the end-of-stop pop -> push accepted, fifo_count stays 4, overflow stays 0.
REQ-036 Assert rst at cycle 15 of a frame -> tx_serial=1 and fifo_empty=1 in the same cycle; no tx_done follows.
REQ-037 With UART_TX_PARITY_EN, push 0x07 -> parity bit 1 after data, frame length 44 cycles.
